ram_sp_clr: RTL and testbench

//  Parametrised single-port synchronous RAM for the CPU data path. Successor to the fixed 64x16 ram_1port.

---
 rtl/ram_sp_clr_pkg.sv | 12 +
 rtl/ram_sp_clr_if.sv | 25 ++
 rtl/ram_sp_clr_clear_ctrl.sv | 53 +++++
 rtl/ram_sp_clr.sv | 87 ++++++++
 tb/tb_ram_sp_clr.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_sp_clr_pkg.sv
// Shared types and constants for the single-port RAM with clear engine.
package ram_sp_clr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam bit RDW_OLD = 1'b0;
    localparam bit RDW_NEW = 1'b1;

endpackage

// File: rtl/ram_sp_clr_if.sv
// Data-port bundle between the CPU load/store stage (master) and the RAM (slave).
interface ram_sp_clr_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data;
    logic                wren;
    logic [DATA_W/8-1:0] byteena;
    logic                rden;
    logic                clear;
    logic                busy;
    logic [DATA_W-1:0]   q;
    logic                q_valid;

    modport master (
        output address, data, wren, byteena, rden, clear,
        input  busy, q, q_valid
    );

    modport slave (
        input  address, data, wren, byteena, rden, clear,
        output busy, q, q_valid
    );
endinterface

// File: rtl/ram_sp_clr_clear_ctrl.sv
// Clear engine: sweeps a pointer over every word, one write per cycle.
// state    | meaning
// ST_IDLE  | port owns the array, waiting for a clear request
// ST_CLEAR | writing INIT_VAL at ptr, ptr advancing each cycle
module ram_sp_clr_clear_ctrl
    import ram_sp_clr_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_e        state_d, state_q;
    logic [ADDR_W-1:0] ptr_d, ptr_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                ptr_d = '0;
                if (clear) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                // pointer wraps to 0 exactly as the last word is written
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_we   = busy && !reset;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with byte enables, registered read + valid strobe,
// selectable read-during-write behaviour and a built-in clear sweep.
module ram_sp_clr
    import ram_sp_clr_pkg::*;
#(
    parameter int              ADDR_W         = 6,
    parameter int              DATA_W         = 16,
    parameter bit              RDW_MODE       = RDW_OLD,
    parameter logic [DATA_W-1:0] INIT_VAL     = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    ram_sp_clr_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("ram_sp_clr: DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              port_ok, port_we, port_rd;
    logic [DATA_W-1:0] rd_word, merged;
    logic [DATA_W-1:0] q_d, q_q;
    logic              q_valid_d, q_valid_q;

    ram_sp_clr_clear_ctrl #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clock    (clock),
        .reset    (reset),
        .clear    (bus.clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // a clear request in idle takes precedence over any access in the same cycle
    always_comb begin
        port_ok   = !reset && !busy && !bus.clear;
        port_we   = port_ok && bus.wren && (|bus.byteena);
        port_rd   = port_ok && bus.rden;
        rd_word   = mem[bus.address];
        merged    = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.byteena[i]) merged[8*i +: 8] = bus.data[8*i +: 8];
        end
        q_d       = q_q;
        q_valid_d = 1'b0;
        if (port_rd) begin
            q_valid_d = 1'b1;
            q_d       = (RDW_MODE == RDW_NEW && port_we) ? merged : rd_word;
        end
    end

    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (port_we) begin
            mem[bus.address] <= merged;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign bus.busy    = busy;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench: two RAM configurations driven in lockstep, checked against a word-level model.
module tb_ram_sp_clr;

    logic        clk = 1'b0;
    logic        rst, wr, rd, clr;
    logic [5:0]  addr;
    logic [15:0] din;
    logic [1:0]  be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_sp_clr_if #(.ADDR_W(6), .DATA_W(16)) if_a ();
    ram_sp_clr_if #(.ADDR_W(6), .DATA_W(16)) if_b ();

    assign if_a.address = addr; assign if_b.address = addr;
    assign if_a.data    = din;  assign if_b.data    = din;
    assign if_a.wren    = wr;   assign if_b.wren    = wr;
    assign if_a.byteena = be;   assign if_b.byteena = be;
    assign if_a.rden    = rd;   assign if_b.rden    = rd;
    assign if_a.clear   = clr;  assign if_b.clear   = clr;

    // A: old-data RDW, clears to 0, sweeps on reset.  B: new-data RDW, clears to 5A5A, idle on reset.
    ram_sp_clr #(.ADDR_W(6), .DATA_W(16), .RDW_MODE(1'b0), .INIT_VAL(16'h0000),
                 .CLEAR_ON_RESET(1'b1))
        dut_a (.clock(clk), .reset(rst), .bus(if_a));
    ram_sp_clr #(.ADDR_W(6), .DATA_W(16), .RDW_MODE(1'b1), .INIT_VAL(16'h5A5A),
                 .CLEAR_ON_RESET(1'b0))
        dut_b (.clock(clk), .reset(rst), .bus(if_b));

    // model: per config, array + known-bitmap, remaining sweep cycles, q state
    logic [15:0] m_mem   [2][64];
    bit          m_known [2][64];
    logic [15:0] m_q     [2];
    bit          m_qk    [2];
    bit          m_qv    [2];
    int          m_rem   [2];

    function automatic void model(int d);
        logic [15:0] init = (d == 0) ? 16'h0000 : 16'h5A5A;
        bit          cor  = (d == 0);
        bit          rdw  = (d == 1);
        logic [15:0] old, mrg;
        bit          ok;
        if (rst) begin
            if (!cor && m_rem[d] > 0)
                for (int i = 0; i < 64; i++) m_known[d][i] = 1'b0;
            m_rem[d] = cor ? 64 : 0;
            m_q[d]   = 16'h0000;
            m_qk[d]  = 1'b1;
            m_qv[d]  = 1'b0;
        end else if (m_rem[d] > 0) begin
            m_rem[d] = m_rem[d] - 1;
            m_qv[d]  = 1'b0;
            if (m_rem[d] == 0)
                for (int i = 0; i < 64; i++) begin
                    m_mem[d][i]   = init;
                    m_known[d][i] = 1'b1;
                end
        end else if (clr) begin
            m_rem[d] = 64;
            m_qv[d]  = 1'b0;
        end else begin
            old = m_mem[d][addr];
            ok  = m_known[d][addr];
            mrg = {be[1] ? din[15:8] : old[15:8], be[0] ? din[7:0] : old[7:0]};
            m_qv[d] = rd;
            if (rd) begin
                m_q[d]  = (rdw && wr) ? mrg : old;
                m_qk[d] = (rdw && wr) ? (ok || be == 2'b11) : ok;
            end
            if (wr) begin
                m_mem[d][addr]   = mrg;
                m_known[d][addr] = ok || (be == 2'b11);
            end
        end
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic        o_busy, o_qv;
        logic [15:0] o_q;
        for (int d = 0; d < 2; d++) begin
            o_busy = (d == 0) ? if_a.busy    : if_b.busy;
            o_qv   = (d == 0) ? if_a.q_valid : if_b.q_valid;
            o_q    = (d == 0) ? if_a.q       : if_b.q;
            chk($sformatf("busy%0d", d), {15'b0, o_busy}, {15'b0, (m_rem[d] > 0)});
            chk($sformatf("q_valid%0d", d), {15'b0, o_qv}, {15'b0, m_qv[d]});
            if (m_qk[d]) chk($sformatf("q%0d", d), o_q, m_q[d]);
        end
    endtask

    task automatic step(logic r, logic w, logic rr, logic c,
                        logic [5:0] a, logic [15:0] dv, logic [1:0] b);
        rst = r; wr = w; rd = rr; clr = c; addr = a; din = dv; be = b;
        @(posedge clk);
        model(0);
        model(1);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
    endtask

    initial begin
        int cnt;
        rst = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; addr = '0; din = '0; be = '0;
        for (int d = 0; d < 2; d++) begin
            m_rem[d] = 0; m_q[d] = '0; m_qk[d] = 1'b0; m_qv[d] = 1'b0;
            for (int i = 0; i < 64; i++) begin m_mem[d][i] = '0; m_known[d][i] = 1'b0; end
        end
        #2;

        // reset, power-up sweep on A; B is started by an explicit clear
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        chk("rst_busy_a", {15'b0, if_a.busy}, 16'h0001);
        chk("rst_busy_b", {15'b0, if_b.busy}, 16'h0000);
        chk("rst_q_a", if_a.q, 16'h0000);
        cnt = int'(if_a.busy);
        step(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 16'h0000, 2'b00);
        cnt += int'(if_a.busy);
        for (int i = 0; i < 69; i++) begin idle(); cnt += int'(if_a.busy); end
        chk("t1_busy_len", 16'(cnt), 16'd64);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 16'h0000, 2'b00);
        chk("t1_rd_a", if_a.q, 16'h0000);
        chk("t1_qv_a", {15'b0, if_a.q_valid}, 16'h0001);
        chk("t1_rd_b", if_b.q, 16'h5A5A);
        idle();
        chk("t1_qv_drop", {15'b0, if_a.q_valid}, 16'h0000);

        // plain writes and read-back
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 16'h0002, 2'b11);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 16'h0000, 2'b00);
        chk("t2_rd1", if_a.q, 16'h0002);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd3, 16'h0004, 2'b11);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 16'h0000, 2'b00);
        chk("t2_rd3", if_a.q, 16'h0004);

        // byte enables
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd3, 16'h1234, 2'b11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd3, 16'hABCD, 2'b01);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 16'h0000, 2'b00);
        chk("t3_be01", if_a.q, 16'h12CD);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd3, 16'hFFFF, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6'd3, 16'h0000, 2'b00);
        chk("t3_be00", if_b.q, 16'h12CD);

        // read-during-write
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 16'h0002, 2'b11);
        step(1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 16'h0006, 2'b11);
        chk("t4_rdw_old", if_a.q, 16'h0002);
        chk("t4_rdw_new", if_b.q, 16'h0006);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 16'h0000, 2'b00);
        chk("t4_after_a", if_a.q, 16'h0006);
        chk("t4_after_b", if_b.q, 16'h0006);

        // clear with ignored write and re-clear while busy
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'd5, 16'h7777, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 16'h0000, 2'b00);
        cnt = int'(if_b.busy);
        step(1'b0, 1'b1, 1'b0, 1'b1, 6'd5, 16'hFFFF, 2'b11);
        cnt += int'(if_b.busy);
        for (int i = 0; i < 68; i++) begin idle(); cnt += int'(if_b.busy); end
        chk("t5_busy_len", 16'(cnt), 16'd64);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6'd5, 16'h0000, 2'b00);
        chk("t5_rd5_b", if_b.q, 16'h5A5A);
        chk("t5_rd5_a", if_a.q, 16'h0000);

        // reset in the middle of a sweep
        step(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 16'h0000, 2'b00);
        for (int i = 0; i < 19; i++) idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
        chk("t6_q_b", if_b.q, 16'h0000);
        chk("t6_busy_b", {15'b0, if_b.busy}, 16'h0000);
        cnt = int'(if_a.busy);
        for (int i = 0; i < 70; i++) begin idle(); cnt += int'(if_a.busy); end
        chk("t6_busy_len", 16'(cnt), 16'd64);

        // bring B back to a known state, then random traffic
        step(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 16'h0000, 2'b00);
        for (int i = 0; i < 66; i++) idle();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 59) == 0),
                 6'($urandom_range(0, 63)),
                 16'($urandom),
                 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
